// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage sitting behind decode/ALU.
// Runs one transaction at a time on a req/gnt/rvalid data-memory port.
// Returns an aligned, sign- or zero-extended load result for writeback.
// Optional feature macro: MISALIGN_TRAP_EN adds the `misalign` output.
// With the macro, misaligned SH/SW trap without touching memory.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ready,
    input  logic [5:0]  alucode,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic [31:0] load_data,
    output logic [4:0]  rd_out,
    output logic        reg_we_out,
    output logic        bus_err
`ifdef MISALIGN_TRAP_EN
   ,output logic        misalign
`endif
);

    // Load/store alucodes, matching the decoder's define.vh encoding
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    // A limit of zero means the timeout never fires
    localparam bit         TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    function automatic logic is_ld_code(input logic [5:0] op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU);
    endfunction

    function automatic logic is_st_code(input logic [5:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] off);
        case (op)
            ALU_SB:  return 4'b0001 << off;
            ALU_SH:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store data across all byte lanes so the enables pick the lane
    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] d);
        case (op)
            ALU_SB:  return {4{d[7:0]}};
            ALU_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            ALU_LB:  return {{24{b[7]}}, b};
            ALU_LBU: return {24'd0, b};
            ALU_LH:  return {{16{h[15]}}, h};
            ALU_LHU: return {16'd0, h};
            default: return w;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        reg_we_out_q, reg_we_out_d;
    logic        bus_err_q, bus_err_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    logic ld_ok, st_ok, to_hit;

    // Next-state and registered-output computation for the access FSM
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        load_data_d  = load_data_q;
        rd_out_d     = rd_out_q;
        reg_we_out_d = 1'b0;
        bus_err_d    = 1'b0;
        op_d         = op_q;
        off_d        = off_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d   = 1'b0;
`endif
        ld_ok  = is_load && !is_store && is_ld_code(alucode);
        st_ok  = is_store && !is_load && is_st_code(alucode);
        to_hit = TO_EN && (({1'b0, cnt_q} + 9'd1) >= TO_LIM);

        case (state_q)
            S_IDLE: begin
                if (start && (is_load || is_store)) begin
                    ready_d  = 1'b0;
                    rd_out_d = rd_in;
                    if (ld_ok || st_ok) begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = st_ok;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = st_ok ? store_be(alucode, addr[1:0]) : 4'b1111;
                        mem_wdata_d = st_ok ? store_data(alucode, wdata) : 32'd0;
                        op_d        = alucode;
                        off_d       = addr[1:0];
                        rd_d        = rd_in;
                        cnt_d       = 8'd0;
`ifdef MISALIGN_TRAP_EN
                        // Misaligned halfword/word stores trap before any bus activity
                        if (st_ok && (((alucode == ALU_SH) && addr[0]) ||
                                      ((alucode == ALU_SW) && (addr[1:0] != 2'b00)))) begin
                            state_d     = S_DONE;
                            mem_req_d   = mem_req_q;
                            mem_we_d    = mem_we_q;
                            mem_addr_d  = mem_addr_q;
                            mem_be_d    = mem_be_q;
                            mem_wdata_d = mem_wdata_q;
                            done_d      = 1'b1;
                            load_data_d = 32'd0;
                            misalign_d  = 1'b1;
                        end
`endif
                    end else begin
                        // Conflicting op flags or alucode mismatch: complete with no access
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        load_data_d = 32'd0;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = cnt_q + 8'd1;
                    if (mem_we_q) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        rd_out_d = rd_q;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end else if (to_hit) begin
                    state_d     = S_DONE;
                    mem_req_d   = 1'b0;
                    done_d      = 1'b1;
                    bus_err_d   = 1'b1;
                    load_data_d = 32'd0;
                    rd_out_d    = rd_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    load_data_d  = load_extract(op_q, off_q, mem_rdata);
                    rd_out_d     = rd_q;
                    reg_we_out_d = (rd_q != 5'd0);
                end else if (to_hit) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    bus_err_d   = 1'b1;
                    load_data_d = 32'd0;
                    rd_out_d    = rd_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d   = S_IDLE;
                ready_d   = 1'b1;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the bus request immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            done_q       <= 1'b0;
            load_data_q  <= 32'd0;
            rd_out_q     <= 5'd0;
            reg_we_out_q <= 1'b0;
            bus_err_q    <= 1'b0;
            op_q         <= 6'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            cnt_q        <= 8'd0;
`ifdef MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
            rd_out_q     <= rd_out_d;
            reg_we_out_q <= reg_we_out_d;
            bus_err_q    <= bus_err_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign ready      = ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign load_data  = load_data_q;
    assign rd_out     = rd_out_q;
    assign reg_we_out = reg_we_out_q;
    assign bus_err    = bus_err_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a result scoreboard.
// A second instance with a short timeout limit exercises the bus-error path.
module tb_lsu_mem_stage;

    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    typedef struct {
        logic [31:0] ld;
        logic        chk_ld;
        logic [4:0]  rd;
        logic        we;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start_to = 1'b0;
    logic [5:0]  alucode = '0;
    logic        is_load = 1'b0, is_store = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [4:0]  rd_in = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        ready, mem_req, mem_we, done, reg_we_out, bus_err;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;
    logic [4:0]  rd_out;
    logic        ready_t, mem_req_t, mem_we_t, done_t, reg_we_t, bus_err_t;
    logic [31:0] mem_addr_t, mem_wdata_t, load_data_t;
    logic [3:0]  mem_be_t;
    logic [4:0]  rd_out_t;
`ifdef MISALIGN_TRAP_EN
    logic        misalign, misalign_t;
`endif

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .alucode(alucode),
        .is_load(is_load), .is_store(is_store), .addr(addr), .wdata(wdata), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .done(done), .load_data(load_data), .rd_out(rd_out),
        .reg_we_out(reg_we_out), .bus_err(bus_err)
`ifdef MISALIGN_TRAP_EN
       ,.misalign(misalign)
`endif
    );

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .start(start_to), .ready(ready_t), .alucode(alucode),
        .is_load(is_load), .is_store(is_store), .addr(addr), .wdata(wdata), .rd_in(rd_in),
        .mem_req(mem_req_t), .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_be(mem_be_t),
        .mem_wdata(mem_wdata_t), .mem_gnt(1'b0), .mem_rvalid(1'b0),
        .mem_rdata(mem_rdata), .done(done_t), .load_data(load_data_t), .rd_out(rd_out_t),
        .reg_we_out(reg_we_t), .bus_err(bus_err_t)
`ifdef MISALIGN_TRAP_EN
       ,.misalign(misalign_t)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and play the memory side: gnt after gnt_dly REQ cycles (-1 = never),
    // rvalid rv_dly cycles after gnt; spurious rvalid is driven while still in REQ.
    task automatic do_txn(input string tag, input logic [5:0] op, input logic ld, input logic st,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input bit exp_mem,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] rdat, input int exp_lat, input exp_t e);
        bit seen = 0;
        exp_t got;
        sb.push_back(e);
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        alucode = op; is_load = ld; is_store = st; addr = a; wdata = wd; rd_in = rd;
        start = 1'b1;
        step();
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        addr = $urandom; wdata = $urandom; rd_in = 5'($urandom); alucode = 6'($urandom);
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            if (exp_mem) chk({tag, ".req"}, 32'(mem_req), 32'(gnt_dly >= 0 ? cyc <= 1 + gnt_dly : 1));
            else         chk({tag, ".noreq"}, 32'(mem_req), 32'd0);
            if (mem_req === 1'b1) begin
                chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
                chk({tag, ".be"}, 32'(mem_be), 32'(ebe));
                chk({tag, ".we"}, 32'(mem_we), 32'(st));
                if (st) chk({tag, ".wdata"}, mem_wdata, ewd);
            end
            if (done === 1'b1) begin
                seen = 1;
                chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
                got = sb.pop_front();
                if (got.chk_ld) chk({tag, ".load_data"}, load_data, got.ld);
                if (got.we) chk({tag, ".rd_out"}, 32'(rd_out), 32'(got.rd));
                chk({tag, ".reg_we"}, 32'(reg_we_out), 32'(got.we));
                chk({tag, ".bus_err"}, 32'(bus_err), 32'(got.err));
            end
            mem_gnt    = exp_mem && (cyc == 1 + gnt_dly);
            mem_rvalid = exp_mem && ld && ((cyc == 1 + gnt_dly + rv_dly) || (cyc <= gnt_dly));
            mem_rdata  = (cyc == 1 + gnt_dly + rv_dly) ? rdat : $urandom;
            step();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!seen) begin
            chk({tag, ".done_seen"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        // Reset state
        repeat (2) step();
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_be", 32'(mem_be), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.load_data", load_data, 32'd0);
        chk("rst.rd_out", 32'(rd_out), 32'd0);
        chk("rst.reg_we", 32'(reg_we_out), 32'd0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;
        step();

        // Stores
        e = '{ld: 32'd0, chk_ld: 1'b0, rd: 5'd0, we: 1'b0, err: 1'b0};
        do_txn("sw", ALU_SW, 0, 1, 32'h104, 32'hDEADBEEF, 5'd3, 0, 0, 1, 4'b1111, 32'hDEADBEEF, 0, 2, e);
        do_txn("sb", ALU_SB, 0, 1, 32'h103, 32'h000000A5, 5'd3, 0, 0, 1, 4'b1000, 32'hA5A5A5A5, 0, 2, e);
        do_txn("sb0", ALU_SB, 0, 1, 32'h100, 32'h1234563C, 5'd3, 2, 0, 1, 4'b0001, 32'h3C3C3C3C, 0, 4, e);
        do_txn("sh", ALU_SH, 0, 1, 32'h102, 32'h12345678, 5'd3, 1, 0, 1, 4'b1100, 32'h56785678, 0, 3, e);
`ifndef MISALIGN_TRAP_EN
        do_txn("sh_odd", ALU_SH, 0, 1, 32'h101, 32'h0000BEEF, 5'd3, 0, 0, 1, 4'b0011, 32'hBEEFBEEF, 0, 2, e);
        do_txn("sw_odd", ALU_SW, 0, 1, 32'h10B, 32'hCAFEBABE, 5'd3, 0, 0, 1, 4'b1111, 32'hCAFEBABE, 0, 2, e);
`endif

        // Loads
        e = '{ld: 32'hFFFFFF80, chk_ld: 1'b1, rd: 5'd5, we: 1'b1, err: 1'b0};
        do_txn("lb", ALU_LB, 1, 0, 32'h202, 0, 5'd5, 0, 1, 1, 4'b1111, 0, 32'h0080FF00, 3, e);
        e.ld = 32'h00000080;
        do_txn("lbu", ALU_LBU, 1, 0, 32'h202, 0, 5'd5, 0, 1, 1, 4'b1111, 0, 32'h0080FF00, 3, e);
        do_txn("lhu", ALU_LHU, 1, 0, 32'h202, 0, 5'd5, 0, 1, 1, 4'b1111, 0, 32'h0080FF00, 3, e);
        e.ld = 32'hFFFFFF00; e.rd = 5'd31;
        do_txn("lh", ALU_LH, 1, 0, 32'h200, 0, 5'd31, 1, 2, 1, 4'b1111, 0, 32'h0080FF00, 5, e);
        e.ld = 32'h0000007F; e.rd = 5'd1;
        do_txn("lb3", ALU_LB, 1, 0, 32'h303, 0, 5'd1, 0, 1, 1, 4'b1111, 0, 32'h7F80FF00, 3, e);
        e = '{ld: 32'hCAFEF00D, chk_ld: 1'b1, rd: 5'd0, we: 1'b0, err: 1'b0};
        do_txn("lw_rd0", ALU_LW, 1, 0, 32'h400, 0, 5'd0, 3, 2, 1, 4'b1111, 0, 32'hCAFEF00D, 7, e);

        // Illegal combinations finish immediately without memory traffic
        e = '{ld: 32'd0, chk_ld: 1'b1, rd: 5'd7, we: 1'b0, err: 1'b0};
        do_txn("mismatch", ALU_SB, 1, 0, 32'h500, 0, 5'd7, 0, 0, 0, 4'b0, 0, 0, 1, e);
        do_txn("both", ALU_LW, 1, 1, 32'h500, 0, 5'd7, 0, 0, 0, 4'b0, 0, 0, 1, e);

        // Start with neither op flag is ignored
        alucode = ALU_LW; addr = 32'h600; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("neither.ready", 32'(ready), 32'd1);
            chk("neither.done", 32'(done), 32'd0);
            chk("neither.req", 32'(mem_req), 32'd0);
            step();
        end

        // Timeout on the short-limit instance: REQ for 4 cycles, then done+bus_err
        chk("to.ready", 32'(ready_t), 32'd1);
        alucode = ALU_LW; is_load = 1'b1; addr = 32'h700; rd_in = 5'd9; start_to = 1'b1;
        step();
        start_to = 1'b0; is_load = 1'b0;
        seen = 0;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            chk("to.req", 32'(mem_req_t), 32'(cyc <= 4));
            if (done_t === 1'b1) begin
                seen = 1;
                chk("to.latency", 32'(cyc), 32'd5);
                chk("to.bus_err", 32'(bus_err_t), 32'd1);
                chk("to.reg_we", 32'(reg_we_t), 32'd0);
                chk("to.load_data", load_data_t, 32'd0);
            end
            step();
        end
        if (!seen) chk("to.done_seen", 32'd0, 32'd1);
        chk("to.ready_after", 32'(ready_t), 32'd1);
        chk("to.req_after", 32'(mem_req_t), 32'd0);
        chk("to.done_after", 32'(done_t), 32'd0);

        // Reset while waiting for read data: late rvalid must not complete anything
        alucode = ALU_LW; is_load = 1'b1; addr = 32'h800; rd_in = 5'd4; start = 1'b1;
        step();
        start = 1'b0; is_load = 1'b0;
        chk("rstw.req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rstw.in_wait", 32'(mem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw.ready_async", 32'(ready), 32'd1);
        chk("rstw.req_async", 32'(mem_req), 32'd0);
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h11223344; mem_gnt = 1'b1;
        step();
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstw.no_done", 32'(done), 32'd0);
            chk("rstw.ready", 32'(ready), 32'd1);
            chk("rstw.no_req", 32'(mem_req), 32'd0);
            step();
        end

        // Normal traffic resumes after the reset
        e = '{ld: 32'h11223344, chk_ld: 1'b1, rd: 5'd4, we: 1'b1, err: 1'b0};
        do_txn("lw_post", ALU_LW, 1, 0, 32'h804, 0, 5'd4, 0, 1, 1, 4'b1111, 0, 32'h11223344, 3, e);

`ifdef MISALIGN_TRAP_EN
        alucode = ALU_SH; is_store = 1'b1; addr = 32'h1; wdata = 32'h1234; start = 1'b1;
        step();
        start = 1'b0; is_store = 1'b0;
        chk("mis.done", 32'(done), 32'd1);
        chk("mis.flag", 32'(misalign), 32'd1);
        chk("mis.req", 32'(mem_req), 32'd0);
        chk("mis.reg_we", 32'(reg_we_out), 32'd0);
        step();
        chk("mis.clear", 32'(misalign), 32'd0);
        chk("mis.ready", 32'(ready), 32'd1);
        step();
`endif

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
